// File: rtl/ysyx_22040127_pkg.sv
// ysyx_22040127_pkg: shared fetch constants and fetch state encoding
package ysyx_22040127_pkg;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int XLEN = 64;
    typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_OUT = 2'd2} state_e;
endpackage

// File: rtl/ysyx_22040127_ifu_if.sv
// ysyx_22040127_ifu_if: redirect, memory port and decode-side signals of the fetch unit
interface ysyx_22040127_ifu_if;
    import ysyx_22040127_pkg::*;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [31:0]     inst_pc;
    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
        output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc
    );
    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
        input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/ysyx_22040127_ifu_linebuf.sv
// ysyx_22040127_ifu_linebuf: one-entry doubleword buffer with tag compare and word select
module ysyx_22040127_ifu_linebuf
    import ysyx_22040127_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            fill_i,
    input  logic [28:0]     fill_tag_i,
    input  logic [XLEN-1:0] fill_data_i,
    input  logic [28:0]     lookup_tag_i,
    input  logic            sel_i,
    output logic            hit_o,
    output logic [31:0]     inst_o
);
    logic            valid_q;
    logic [28:0]     tag_q;
    logic [XLEN-1:0] data_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag_i;
            data_q  <= fill_data_i;
        end
    end
    // A fill landing this cycle is what the lookup will see next cycle, so compare against it.
    assign hit_o  = fill_i ? fill_tag_i == lookup_tag_i : valid_q && tag_q == lookup_tag_i;
    assign inst_o = sel_i ? data_q[63:32] : data_q[31:0];
endmodule

// File: rtl/ysyx_22040127_ifu.sv
// ysyx_22040127_ifu: PC, fetch FSM and redirect/discard handling in front of decode
module ysyx_22040127_ifu
    import ysyx_22040127_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ysyx_22040127_pkg::RESET_PC
) (
    input logic               clk,
    input logic               rst,
    ysyx_22040127_ifu_if.master bus_io
);
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [28:0] req_tag_q, req_tag_d;
    logic        discard_q, discard_d;
    logic        fill, lookup, hit;
    assign fill      = state_q == S_WAIT && bus_io.mem_resp_valid;
    assign pc_d      = bus_io.redirect_valid ? bus_io.redirect_pc & 32'hffff_fffc :
                       state_q == S_OUT && bus_io.inst_ready ? pc_q + 32'd4 : pc_q;
    // The outstanding request address must survive until its response fills the buffer.
    assign req_tag_d = state_q == S_OUT || fill ? pc_d[31:3] : req_tag_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            req_tag_q <= RESET_PC[31:3];
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_tag_q <= req_tag_d;
            discard_q <= discard_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        lookup    = 1'b0;
        case (state_q)
            S_REQ: begin
                state_d   = bus_io.mem_req_ready ? S_WAIT : S_REQ;
                discard_d = discard_q || bus_io.redirect_valid;
            end
            S_WAIT: begin
                state_d   = fill ? S_OUT : S_WAIT;
                discard_d = !fill && (discard_q || bus_io.redirect_valid);
                lookup    = fill && (discard_q || bus_io.redirect_valid);
            end
            S_OUT: lookup = bus_io.redirect_valid || bus_io.inst_ready;
            default: state_d = S_REQ;
        endcase
        if (lookup) state_d = hit ? S_OUT : S_REQ;
    end
    ysyx_22040127_ifu_linebuf u_buf (
        .clk          (clk),
        .rst          (rst),
        .fill_i       (fill),
        .fill_tag_i   (req_tag_q),
        .fill_data_i  (bus_io.mem_resp_data),
        .lookup_tag_i (pc_d[31:3]),
        .sel_i        (pc_q[2]),
        .hit_o        (hit),
        .inst_o       (bus_io.inst)
    );
    assign bus_io.mem_req_valid = !rst && state_q == S_REQ;
    assign bus_io.mem_req_addr  = {{(XLEN-32){1'b0}}, req_tag_q, 3'b000};
    assign bus_io.inst_valid    = !rst && state_q == S_OUT;
    assign bus_io.inst_pc       = pc_q;
endmodule
